// File: rtl/dma_fifo_pkg.sv
// Shared constants for the DMA byte/longword FIFO: DIR encodings, big-endian
// byte-lane indices and the default depth.
package dma_fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    DIR_MEM2SCSI = 1'b0,
    DIR_SCSI2MEM = 1'b1
  } dir_e;

  localparam logic [1:0] LANE_B31_24 = 2'd0;
  localparam logic [1:0] LANE_B23_16 = 2'd1;
  localparam logic [1:0] LANE_B15_8  = 2'd2;
  localparam logic [1:0] LANE_B7_0   = 2'd3;

  // Byte pointer to lane write-enable; bit3 is the most significant lane
  function automatic logic [3:0] lane_onehot(input logic [1:0] bo);
    case (bo)
      LANE_B31_24: lane_onehot = 4'b1000;
      LANE_B23_16: lane_onehot = 4'b0100;
      LANE_B15_8:  lane_onehot = 4'b0010;
      LANE_B7_0:   lane_onehot = 4'b0001;
      default:     lane_onehot = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dma_byte_fifo_if.sv
// Handshake/data bundle of the DMA byte FIFO. AFULL/AEMPTY exist only when
// DMA_FIFO_WATERMARK_EN is defined.
interface dma_byte_fifo_if #(
  parameter int DEPTH = dma_fifo_pkg::DEFAULT_DEPTH
);
  logic                     CLR;
  logic                     DIR;
  logic                     LSTB;
  logic [3:0]               LBE;
  logic [31:0]              ID;
  logic [31:0]              OD;
  logic                     BSTB;
  logic [7:0]               BDIN;
  logic [7:0]               BDOUT;
  logic                     FLUSH;
  logic                     FULL;
  logic                     EMPTY;
  logic [$clog2(DEPTH):0]   COUNT;
  logic [1:0]               BO;
  logic                     BOEQ0;
  logic                     BOEQ3;
  logic                     OVF;
  logic                     UNF;
`ifdef DMA_FIFO_WATERMARK_EN
  logic                     AFULL;
  logic                     AEMPTY;
`endif

  modport master (
    output CLR, DIR, LSTB, LBE, ID, BSTB, BDIN, FLUSH,
`ifdef DMA_FIFO_WATERMARK_EN
    input  AFULL, AEMPTY,
`endif
    input  OD, BDOUT, FULL, EMPTY, COUNT, BO, BOEQ0, BOEQ3, OVF, UNF
  );

  modport slave (
    input  CLR, DIR, LSTB, LBE, ID, BSTB, BDIN, FLUSH,
`ifdef DMA_FIFO_WATERMARK_EN
    output AFULL, AEMPTY,
`endif
    output OD, BDOUT, FULL, EMPTY, COUNT, BO, BOEQ0, BOEQ3, OVF, UNF
  );

endinterface

// File: rtl/dma_fifo_ptr.sv
// Pointer, byte-pointer, count and flag state of the DMA byte FIFO.
// Watermark flags are built only with DMA_FIFO_WATERMARK_EN.
module dma_fifo_ptr
  import dma_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
`ifdef DMA_FIFO_WATERMARK_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     dir,
  input  logic                     lstb,
  input  logic                     bstb,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] wptr,
  output logic [$clog2(DEPTH)-1:0] rptr,
  output logic [1:0]               bo,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     boeq0,
  output logic                     boeq3,
  output logic                     ovf,
  output logic                     unf,
`ifdef DMA_FIFO_WATERMARK_EN
  output logic                     afull,
  output logic                     aempty,
`endif
  output logic                     lpush_ok,
  output logic                     bpush_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
  logic [1:0]    bo_r, bo_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          full_r, empty_r, boeq0_r, boeq3_r, ovf_r, unf_r;
  logic          ovf_nxt_s, unf_nxt_s;
  logic          push_req_s, pop_req_s, lpop_ok_s, bpop_ok_s, flush_ok_s;
  logic          inc_s, dec_s;
`ifdef DMA_FIFO_WATERMARK_EN
  logic          afull_r, aempty_r;
`endif

  // Qualify strobes against current occupancy; a byte push wins over FLUSH
  always_comb begin
    push_req_s  = (dir == DIR_SCSI2MEM) ? bstb : lstb;
    pop_req_s   = (dir == DIR_SCSI2MEM) ? lstb : bstb;
    lpush_ok    = 1'b0;
    bpush_ok    = 1'b0;
    lpop_ok_s   = 1'b0;
    bpop_ok_s   = 1'b0;
    flush_ok_s  = 1'b0;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    if (clr) begin
      ovf_nxt_s = 1'b0;
      unf_nxt_s = 1'b0;
    end else begin
      if (push_req_s) begin
        if (full_r) ovf_nxt_s = 1'b1;
        else if (dir == DIR_SCSI2MEM) bpush_ok = 1'b1;
        else lpush_ok = 1'b1;
      end else if (flush && (dir == DIR_SCSI2MEM) && (bo_r != 2'd0)) begin
        if (full_r) ovf_nxt_s = 1'b1;
        else flush_ok_s = 1'b1;
      end else begin
        flush_ok_s = 1'b0;
      end
      if (pop_req_s) begin
        if (empty_r) unf_nxt_s = 1'b1;
        else if (dir == DIR_SCSI2MEM) lpop_ok_s = 1'b1;
        else bpop_ok_s = 1'b1;
      end else begin
        lpop_ok_s = 1'b0;
      end
    end
  end

  // Next-state for pointers, byte pointer and count
  always_comb begin
    inc_s = lpush_ok | flush_ok_s | (bpush_ok & (bo_r == LANE_B7_0));
    dec_s = lpop_ok_s | (bpop_ok_s & (bo_r == LANE_B7_0));
    if (clr) begin
      wptr_nxt_s  = {AW{1'b0}};
      rptr_nxt_s  = {AW{1'b0}};
      bo_nxt_s    = 2'd0;
      count_nxt_s = {CW{1'b0}};
    end else begin
      wptr_nxt_s  = wptr_r + AW'(inc_s);
      rptr_nxt_s  = rptr_r + AW'(dec_s);
      count_nxt_s = count_r + CW'(inc_s) - CW'(dec_s);
      if (flush_ok_s) bo_nxt_s = 2'd0;
      else if (bpush_ok || bpop_ok_s) bo_nxt_s = bo_r + 2'd1;
      else bo_nxt_s = bo_r;
    end
  end

  // State registers; flags are registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r   <= {AW{1'b0}};
      rptr_r   <= {AW{1'b0}};
      bo_r     <= 2'd0;
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      boeq0_r  <= 1'b1;
      boeq3_r  <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
`ifdef DMA_FIFO_WATERMARK_EN
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
`endif
    end else begin
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      bo_r     <= bo_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == {CW{1'b0}});
      boeq0_r  <= (bo_nxt_s == 2'd0);
      boeq3_r  <= (bo_nxt_s == 2'd3);
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
`ifdef DMA_FIFO_WATERMARK_EN
      afull_r  <= (count_nxt_s >= CW'(AF_LEVEL));
      aempty_r <= (count_nxt_s <= CW'(1));
`endif
    end
  end

  assign wptr  = wptr_r;
  assign rptr  = rptr_r;
  assign bo    = bo_r;
  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;
  assign boeq0 = boeq0_r;
  assign boeq3 = boeq3_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;
`ifdef DMA_FIFO_WATERMARK_EN
  assign afull  = afull_r;
  assign aempty = aempty_r;
`endif

endmodule

// File: rtl/dma_byte_fifo.sv
// DMA FIFO bridging 32-bit memory longwords and SCSI bytes in either direction.
// Optional AFULL/AEMPTY watermarks with DMA_FIFO_WATERMARK_EN.
module dma_byte_fifo
  import dma_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
`ifdef DMA_FIFO_WATERMARK_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic          CLK,
  input  logic          RST_FIFO_,
  dma_byte_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wptr_s, rptr_s;
  logic [1:0]    bo_s;
  logic [AW:0]   count_s;
  logic          full_s, empty_s, boeq0_s, boeq3_s, ovf_s, unf_s;
  logic          lpush_ok_s, bpush_ok_s;
  logic [3:0]    lane_we_s;
  logic [31:0]   wdata_s, od_s;
  logic [7:0]    bdout_s;
`ifdef DMA_FIFO_WATERMARK_EN
  logic          afull_s, aempty_s;
`endif

  dma_fifo_ptr #(
    .DEPTH    (DEPTH)
`ifdef DMA_FIFO_WATERMARK_EN
    , .AF_LEVEL (AF_LEVEL)
`endif
  ) u_ptr (
    .clk      (CLK),
    .rst_n    (RST_FIFO_),
    .clr      (bus.CLR),
    .dir      (bus.DIR),
    .lstb     (bus.LSTB),
    .bstb     (bus.BSTB),
    .flush    (bus.FLUSH),
    .wptr     (wptr_s),
    .rptr     (rptr_s),
    .bo       (bo_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s),
    .boeq0    (boeq0_s),
    .boeq3    (boeq3_s),
    .ovf      (ovf_s),
    .unf      (unf_s),
`ifdef DMA_FIFO_WATERMARK_EN
    .afull    (afull_s),
    .aempty   (aempty_s),
`endif
    .lpush_ok (lpush_ok_s),
    .bpush_ok (bpush_ok_s)
  );

  // Lane enables and write data for the entry at the write pointer
  always_comb begin
    lane_we_s = 4'b0000;
    wdata_s   = bus.ID;
    if (lpush_ok_s) begin
      lane_we_s = bus.LBE;
      wdata_s   = bus.ID;
    end else if (bpush_ok_s) begin
      lane_we_s = lane_onehot(bo_s);
      wdata_s   = {4{bus.BDIN}};
    end else begin
      lane_we_s = 4'b0000;
    end
  end

  // Storage has no reset: contents survive both reset and CLR
  always_ff @(posedge CLK) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we_s[l]) begin
        mem_r[wptr_s][8*l +: 8] <= wdata_s[8*l +: 8];
      end
    end
  end

  assign od_s = mem_r[rptr_s];

  // Big-endian lane select for the byte read port
  always_comb begin
    case (bo_s)
      LANE_B31_24: bdout_s = od_s[31:24];
      LANE_B23_16: bdout_s = od_s[23:16];
      LANE_B15_8:  bdout_s = od_s[15:8];
      LANE_B7_0:   bdout_s = od_s[7:0];
      default:     bdout_s = 8'h00;
    endcase
  end

  assign bus.OD    = od_s;
  assign bus.BDOUT = bdout_s;
  assign bus.FULL  = full_s;
  assign bus.EMPTY = empty_s;
  assign bus.COUNT = count_s;
  assign bus.BO    = bo_s;
  assign bus.BOEQ0 = boeq0_s;
  assign bus.BOEQ3 = boeq3_s;
  assign bus.OVF   = ovf_s;
  assign bus.UNF   = unf_s;
`ifdef DMA_FIFO_WATERMARK_EN
  assign bus.AFULL  = afull_s;
  assign bus.AEMPTY = aempty_s;
`endif

endmodule

// File: tb/tb_dma_byte_fifo.sv
// Directed bench for dma_byte_fifo: a transaction-level model (entry totals
// plus slot memory) is compared on every falling edge, with literal spot checks.
module tb_dma_byte_fifo;
  import dma_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST_FIFO_;

  dma_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

  dma_byte_fifo #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_FIFO_ (RST_FIFO_),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b0;

  // model: total entries written/read, byte pointer, sticky flags, slot image
  int          m_wr, m_rd, m_bo;
  bit          m_ovf, m_unf;
  logic [31:0] m_mem   [DEPTH];
  logic [31:0] m_known [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_bo = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  function automatic void model_step();
    int cnt, ws, lane, nbo;
    bit push, pop, full, empty, dw, dr;
    if (bus.CLR) begin
      model_reset();
      return;
    end
    cnt   = m_wr - m_rd;
    full  = (cnt == DEPTH);
    empty = (cnt == 0);
    push  = bus.DIR ? bus.BSTB : bus.LSTB;
    pop   = bus.DIR ? bus.LSTB : bus.BSTB;
    ws    = m_wr % DEPTH;
    nbo   = m_bo;
    dw    = 1'b0;
    dr    = 1'b0;
    if (push) begin
      if (full) m_ovf = 1'b1;
      else if (!bus.DIR) begin
        for (int l = 0; l < 4; l++) begin
          if (bus.LBE[l]) begin
            m_mem[ws][8*l +: 8]   = bus.ID[8*l +: 8];
            m_known[ws][8*l +: 8] = 8'hFF;
          end
        end
        dw = 1'b1;
      end else begin
        lane = 3 - m_bo;
        m_mem[ws][8*lane +: 8]   = bus.BDIN;
        m_known[ws][8*lane +: 8] = 8'hFF;
        dw  = (m_bo == 3);
        nbo = (m_bo + 1) % 4;
      end
    end
    if (pop) begin
      if (empty) m_unf = 1'b1;
      else if (bus.DIR) dr = 1'b1;
      else begin
        dr  = (m_bo == 3);
        nbo = (m_bo + 1) % 4;
      end
    end
    if (bus.FLUSH && bus.DIR && !bus.BSTB && m_bo != 0) begin
      if (full) m_ovf = 1'b1;
      else begin
        dw  = 1'b1;
        nbo = 0;
      end
    end
    m_wr += int'(dw);
    m_rd += int'(dr);
    m_bo  = nbo;
  endfunction

  task automatic compare_all();
    int cnt, rs, lane;
    logic [31:0] ev, msk;
    logic [7:0]  eb, bm;
    cnt  = m_wr - m_rd;
    rs   = m_rd % DEPTH;
    ev   = m_mem[rs];
    msk  = m_known[rs];
    lane = 3 - m_bo;
    eb   = ev[8*lane +: 8];
    bm   = msk[8*lane +: 8];
    chk("count", 32'(bus.COUNT), cnt);
    chk("full",  32'(bus.FULL),  32'(cnt == DEPTH));
    chk("empty", 32'(bus.EMPTY), 32'(cnt == 0));
    chk("bo",    32'(bus.BO),    m_bo);
    chk("boeq0", 32'(bus.BOEQ0), 32'(m_bo == 0));
    chk("boeq3", 32'(bus.BOEQ3), 32'(m_bo == 3));
    chk("ovf",   32'(bus.OVF),   32'(m_ovf));
    chk("unf",   32'(bus.UNF),   32'(m_unf));
    chk("od",    bus.OD & msk,   ev & msk);
    chk("bdout", 32'(bus.BDOUT & bm), 32'(eb & bm));
`ifdef DMA_FIFO_WATERMARK_EN
    chk("afull",  32'(bus.AFULL),  32'(cnt >= DEPTH - 2));
    chk("aempty", 32'(bus.AEMPTY), 32'(cnt <= 1));
`endif
  endtask

  always @(negedge CLK) begin
    if (running) compare_all();
  end

  task automatic cyc(input logic dir, input logic lstb, input logic bstb,
                     input logic [3:0] lbe, input logic [31:0] id,
                     input logic [7:0] bdin, input logic flush, input logic clr);
    bus.DIR = dir; bus.LSTB = lstb; bus.BSTB = bstb; bus.LBE = lbe;
    bus.ID = id; bus.BDIN = bdin; bus.FLUSH = flush; bus.CLR = clr;
    @(posedge CLK);
    if (RST_FIFO_) model_step();
    #1;
    bus.LSTB = 1'b0; bus.BSTB = 1'b0; bus.FLUSH = 1'b0; bus.CLR = 1'b0;
  endtask

  task automatic bpush(input logic [7:0] d);  cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, d, 1'b0, 1'b0); endtask
  task automatic lpush(input logic [31:0] v, input logic [3:0] be); cyc(1'b0, 1'b1, 1'b0, be, v, 8'h00, 1'b0, 1'b0); endtask
  task automatic lpop();  cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 1'b0); endtask
  task automatic bpop();  cyc(1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 8'h00, 1'b0, 1'b0); endtask
  task automatic do_flush(); cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 8'h00, 1'b1, 1'b0); endtask
  task automatic do_clr();   cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 1'b1); endtask

  logic [7:0] bseq [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0; m_known[i] = 32'h0;
    end
    model_reset();
    RST_FIFO_ = 1'b0;
    bus.DIR = 1'b1; bus.LSTB = 1'b0; bus.BSTB = 1'b0; bus.LBE = 4'h0;
    bus.ID = 32'h0; bus.BDIN = 8'h00; bus.FLUSH = 1'b0; bus.CLR = 1'b0;
    running = 1'b1;
    #12;
    chk("rst_empty", 32'(bus.EMPTY), 32'd1);
    chk("rst_full",  32'(bus.FULL),  32'd0);
    chk("rst_boeq0", 32'(bus.BOEQ0), 32'd1);
    chk("rst_boeq3", 32'(bus.BOEQ3), 32'd0);
    chk("rst_count", 32'(bus.COUNT), 32'd0);
    @(negedge CLK); #1 RST_FIFO_ = 1'b1;

    // four byte pushes form one big-endian longword
    bpush(8'h11); bpush(8'h22); bpush(8'h33); bpush(8'h44);
    chk("b4_count", 32'(bus.COUNT), 32'd1);
    chk("b4_od",    bus.OD, 32'h11223344);
    chk("b4_bo",    32'(bus.BO), 32'd0);
    lpop();
    chk("b4_empty", 32'(bus.EMPTY), 32'd1);

    // partial entry committed by FLUSH
    bpush(8'hAA); bpush(8'hBB);
    chk("fl_bo_pre", 32'(bus.BO), 32'd2);
    do_flush();
    chk("fl_count", 32'(bus.COUNT), 32'd1);
    chk("fl_od_hi", 32'(bus.OD[31:16]), 32'h0000AABB);
    chk("fl_bo",    32'(bus.BO), 32'd0);
    lpop();

    // DIR change mid-entry keeps BO, then async reset aborts the entry
    bpush(8'h01); bpush(8'h02);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("dir_bo", 32'(bus.BO), 32'd2);
    #2 RST_FIFO_ = 1'b0;
    model_reset();
    #1;
    chk("arst_bo",    32'(bus.BO),    32'd0);
    chk("arst_count", 32'(bus.COUNT), 32'd0);
    chk("arst_empty", 32'(bus.EMPTY), 32'd1);
    @(negedge CLK); #1 RST_FIFO_ = 1'b1;

    // longword in, bytes out
    bseq[0] = 8'hDE; bseq[1] = 8'hAD; bseq[2] = 8'hBE; bseq[3] = 8'hEF;
    lpush(32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk("bpop_bdout", 32'(bus.BDOUT), 32'(bseq[i]));
      bpop();
    end
    chk("bpop_empty", 32'(bus.EMPTY), 32'd1);
    chk("bpop_unf0",  32'(bus.UNF),   32'd0);
    bpop();
    chk("bpop_unf1",  32'(bus.UNF),   32'd1);
    chk("bpop_count", 32'(bus.COUNT), 32'd0);
    do_clr();
    chk("clr_unf", 32'(bus.UNF), 32'd0);

    // fill to DEPTH, then one more push overflows
    for (int i = 0; i < 9; i++) begin
      lpush(32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF);
      if (i == 7) chk("fill_full", 32'(bus.FULL), 32'd1);
    end
    chk("fill_ovf",   32'(bus.OVF),   32'd1);
    chk("fill_count", 32'(bus.COUNT), 32'd8);

    // push while full with a completing pop: push ignored, pop taken
    bpop(); bpop(); bpop();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 32'h5555AAAA, 8'h00, 1'b0, 1'b0);
    chk("fullpp_count", 32'(bus.COUNT), 32'd7);
    chk("fullpp_full",  32'(bus.FULL),  32'd0);

    // simultaneous valid push and pop at COUNT=3
    do_clr();
    lpush(32'hA1A2A3A4, 4'hF); lpush(32'hB1B2B3B4, 4'hF); lpush(32'hC1C2C3C4, 4'hF);
    bpop(); bpop(); bpop();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 32'hD1D2D3D4, 8'h00, 1'b0, 1'b0);
    chk("pp_count", 32'(bus.COUNT), 32'd3);
    chk("pp_bo",    32'(bus.BO),    32'd0);
    lpush(32'hCAFEF00D, 4'b0101);

    // pop while empty with a completing byte push
    do_clr();
    bpush(8'h10); bpush(8'h20); bpush(8'h30);
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 32'h0, 8'h40, 1'b0, 1'b0);
    chk("emptypp_unf",   32'(bus.UNF),   32'd1);
    chk("emptypp_count", 32'(bus.COUNT), 32'd1);
    chk("emptypp_od",    bus.OD, 32'h10203040);

    // CLR overrides strobes; FLUSH with BO=0 does nothing
    cyc(1'b0, 1'b1, 1'b0, 4'hF, 32'h77777777, 8'h00, 1'b0, 1'b1);
    chk("clrpri_count", 32'(bus.COUNT), 32'd0);
    chk("clrpri_unf",   32'(bus.UNF),   32'd0);
    do_flush();
    chk("flush0_count", 32'(bus.COUNT), 32'd0);

    // pointer wrap-around
    for (int i = 0; i < 12; i++) begin
      lpush(32'h0F0F_0000 + 32'(i), 4'hF);
      lpop();
    end

    @(negedge CLK); #1;
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
